// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Shifts run one bit per cycle. Every other operation completes in a single cycle.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_aluc,
    input  logic        in_shfsrc,
    input  logic        in_jar,
    input  logic        in_jr,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_pc4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_wen,
    output logic        out_redirect,
    output logic [31:0] out_target,
    output logic        out_err
);
    localparam logic [4:0] OP_ADDU = 5'b00000, OP_SUBU = 5'b00001, OP_SLT  = 5'b00010,
                           OP_AND  = 5'b00011, OP_NOR  = 5'b00100, OP_OR   = 5'b00101,
                           OP_XOR  = 5'b00110, OP_SLL  = 5'b00111, OP_SLTU = 5'b01000,
                           OP_SRL  = 5'b01010, OP_SRA  = 5'b10101, OP_JUMP = 5'b10111;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shkind_t;

    state_t      state_q, state_d;
    shkind_t     kind_q, kind_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] result_q, result_d;
    logic [31:0] target_q, target_d;
    logic        wen_q, wen_d;
    logic        redirect_q, redirect_d;
    logic        err_q, err_d;

    logic        accept;
    logic [4:0]  amt;
    logic [31:0] sh_next;

    assign in_ready     = !flush && (state_q == IDLE || (state_q == HOLD && out_ready));
    assign accept       = in_valid && in_ready;
    assign amt          = in_shfsrc ? in_shamt : in_a[4:0];
    assign out_valid    = (state_q == HOLD);
    assign out_result   = result_q;
    assign out_wen      = wen_q;
    assign out_target   = target_q;
    assign out_err      = err_q;
    // Redirect is gated so a stale jump never leaks out while no result is valid.
    assign out_redirect = redirect_q && out_valid;

    always_comb begin
        case (kind_q)
            SK_SLL:  sh_next = {sh_q[30:0], 1'b0};
            SK_SRL:  sh_next = {1'b0, sh_q[31:1]};
            default: sh_next = {sh_q[31], sh_q[31:1]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        result_d   = result_q;
        target_d   = target_q;
        wen_d      = wen_q;
        redirect_d = redirect_q;
        err_d      = err_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                SHIFT: begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = HOLD;
                        result_d = sh_next;
                    end
                end
                HOLD: if (out_ready) state_d = IDLE;
                default: ;
            endcase

            if (accept) begin
                state_d    = HOLD;
                wen_d      = 1'b1;
                err_d      = 1'b0;
                redirect_d = 1'b0;
                target_d   = 32'd0;
                case (in_aluc)
                    OP_ADDU: result_d = in_a + in_b;
                    OP_SUBU: result_d = in_a - in_b;
                    OP_SLT:  result_d = {31'd0, $signed(in_a) < $signed(in_b)};
                    OP_SLTU: result_d = {31'd0, in_a < in_b};
                    OP_AND:  result_d = in_a & in_b;
                    OP_OR:   result_d = in_a | in_b;
                    OP_XOR:  result_d = in_a ^ in_b;
                    OP_NOR:  result_d = ~(in_a | in_b);
                    OP_SLL, OP_SRL, OP_SRA: begin
                        kind_d = (in_aluc == OP_SLL) ? SK_SLL :
                                 (in_aluc == OP_SRL) ? SK_SRL : SK_SRA;
                        sh_d   = in_b;
                        cnt_d  = amt;
                        if (amt == 5'd0) result_d = in_b;
                        else             state_d  = SHIFT;
                    end
                    OP_JUMP: begin
                        redirect_d = 1'b1;
                        target_d   = in_a;
                        if (in_jar) begin
                            result_d = in_pc4 + 32'd4;
                            wen_d    = 1'b1;
                        end else if (in_jr) begin
                            result_d = 32'd0;
                            wen_d    = 1'b0;
                        end else begin
                            result_d = 32'd0;
                            wen_d    = 1'b0;
                        end
                    end
                    default: begin
                        err_d    = 1'b1;
                        wen_d    = 1'b0;
                        result_d = 32'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kind_q     <= SK_SLL;
            cnt_q      <= 5'd0;
            sh_q       <= 32'd0;
            result_q   <= 32'd0;
            target_q   <= 32'd0;
            wen_q      <= 1'b0;
            redirect_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            result_q   <= result_d;
            target_q   <= target_d;
            wen_q      <= wen_d;
            redirect_q <= redirect_d;
            err_q      <= err_d;
        end
    end
endmodule
